// File: rtl/comparator_serial_ctrl.sv
// Serial MSB-first magnitude comparator: one 1-bit compare slice stepped across WIDTH bits.
// Optional build macro COMPARATOR_EARLY_EXIT_EN finishes on the first differing bit.
module comparator_serial_ctrl #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             lesser,
    output logic             greater,
    output logic             equal
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [IDX_W-1:0] idx;
    logic             decided;
    logic             lt;
    logic             gt;

    logic lt_bit;
    logic gt_bit;
    logic decided_nxt;
    logic lt_nxt;
    logic gt_nxt;
    logic last_bit;

    // The operands shift left each cycle so the slice always looks at the MSB,
    // which is bit idx of the captured operands.
    assign lt_bit = ~a_sh[WIDTH-1] &  b_sh[WIDTH-1];
    assign gt_bit =  a_sh[WIDTH-1] & ~b_sh[WIDTH-1];

    // Once decided, lower bits can no longer change the result.
    assign decided_nxt = decided | lt_bit | gt_bit;
    assign lt_nxt      = decided ? lt : lt_bit;
    assign gt_nxt      = decided ? gt : gt_bit;

`ifdef COMPARATOR_EARLY_EXIT_EN
    assign last_bit = (idx == '0) || (!decided && (lt_bit || gt_bit));
`else
    assign last_bit = (idx == '0);
`endif

    assign ready = (state == S_IDLE);
    assign busy  = (state == S_COMPARE);
    assign done  = (state == S_DONE);

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_COMPARE;
            S_COMPARE: if (last_bit) state_nxt = S_DONE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            idx     <= '0;
            decided <= 1'b0;
            lt      <= 1'b0;
            gt      <= 1'b0;
            lesser  <= 1'b0;
            greater <= 1'b0;
            equal   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        idx     <= IDX_TOP;
                        decided <= 1'b0;
                        lt      <= 1'b0;
                        gt      <= 1'b0;
                        lesser  <= 1'b0;
                        greater <= 1'b0;
                        equal   <= 1'b0;
                    end
                end
                S_COMPARE: begin
                    decided <= decided_nxt;
                    lt      <= lt_nxt;
                    gt      <= gt_nxt;
                    a_sh    <= a_sh << 1;
                    b_sh    <= b_sh << 1;
                    // Flags are loaded on the edge into DONE so they are valid with done.
                    if (last_bit) begin
                        lesser  <= lt_nxt;
                        greater <= gt_nxt;
                        equal   <= ~decided_nxt;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_serial_ctrl.sv
// Self-checking bench for comparator_serial_ctrl: directed plan steps plus random operands
// checked against an arithmetic reference model (honours COMPARATOR_EARLY_EXIT_EN).
module tb_comparator_serial_ctrl;

    localparam int W = 3;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic         lesser;
    logic         greater;
    logic         equal;

    int n_checks = 0;
    int n_fail   = 0;

    comparator_serial_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .lesser  (lesser),
        .greater (greater),
        .equal   (equal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {lesser, greater, equal} straight from integer comparison.
    function automatic logic [2:0] exp_flags(input logic [W-1:0] av, input logic [W-1:0] bv);
        return {av < bv, av > bv, av == bv};
    endfunction

    // Cycle offset from the accepting edge to the done cycle.
    function automatic int exp_latency(input logic [W-1:0] av, input logic [W-1:0] bv);
`ifdef COMPARATOR_EARLY_EXIT_EN
        for (int i = W - 1; i >= 0; i--)
            if (av[i] != bv[i]) return (W - i) + 1;
`endif
        return W + 1;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction; optional poke of start while busy, then 'hold' idle cycles.
    task automatic run_cmp(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input bit poke, input int hold);
        int cyc;
        int lat;
        lat = exp_latency(av, bv);
        cyc = 0;
        while (!ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check("ready_before_start", 32'(ready), 32'd1);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cyc   = 1;
        while (!done && cyc < 4 * W + 8) begin
            check("compare_handshake", 32'({busy, ready}), 32'b10);
            check("flags_cleared", 32'({lesser, greater, equal}), 32'b000);
            if (poke && cyc == 1) begin
                a     = '0;
                b     = '1;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(lat));
        check("done_high", 32'(done), 32'd1);
        check("flags", 32'({lesser, greater, equal}), 32'(exp_flags(av, bv)));
        check("done_handshake", 32'({busy, ready}), 32'b00);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("done_pulse", 32'(done), 32'd0);
            check("idle_ready", 32'({busy, ready}), 32'b01);
            check("flags_held", 32'({lesser, greater, equal}), 32'(exp_flags(av, bv)));
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("reset_handshake", 32'({ready, busy, done}), 32'b100);
        check("reset_flags", 32'({lesser, greater, equal}), 32'b000);
        rst = 1'b0;
        tick();

        // Directed plan steps.
        run_cmp(3'b101, 3'b101, 1'b0, 1);
        run_cmp(3'b111, 3'b101, 1'b0, 1);
        run_cmp(3'b100, 3'b011, 1'b0, 1);
        run_cmp(3'b101, 3'b111, 1'b0, 5);
        run_cmp(3'b101, 3'b101, 1'b1, 1);

        // Reset while in COMPARE: start at edge T, rst sampled at edge T+2.
        a     = 3'b101;
        b     = 3'b101;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_pre_busy", 32'(busy), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_handshake", 32'({ready, busy, done}), 32'b100);
        check("rst_mid_flags", 32'({lesser, greater, equal}), 32'b000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_no_done", 32'(done), 32'd0);
        end
        run_cmp(3'b010, 3'b001, 1'b0, 1);

        // Randomised operands against the reference model.
        for (int i = 0; i < 24; i++)
            run_cmp(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(1, 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
